// File: rtl/async_fifo_if.sv
// Producer/consumer bundle for async_fifo.
// Handshake: a write is taken on a rising clk edge when winc=1 and wfull=0;
// a pop is taken on a rising clk edge when rinc=1 and rempty=0. Otherwise the request is dropped.
interface async_fifo_if #(
  parameter int DSIZE = 8
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;

  modport master (
    output winc, wdata, rinc,
    input  wfull, rdata, rempty
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, rdata, rempty
  );
endinterface

// File: rtl/async_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// Head entry is always driven on rdata; flags derive from the registered pointers.
module async_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic        clk,
  input  logic        rst,
  async_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** ASIZE;
  localparam logic [ASIZE:0] PTR_ONE = 1;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             wen;
  logic             ren;
  logic             full;
  logic             empty;

  assign empty = (wptr == rptr);
  // Same slot but different lap: the writer is exactly one lap ahead.
  assign full  = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) && (wptr[ASIZE] != rptr[ASIZE]);

  assign wen = bus.winc && !full;
  assign ren = bus.rinc && !empty;

  assign bus.wfull  = full;
  assign bus.rempty = empty;
  assign bus.rdata  = mem[rptr[ASIZE-1:0]];

  always_ff @(posedge clk) begin
    if (!rst && wen) begin
      mem[wptr[ASIZE-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wen) begin
        wptr <= wptr + PTR_ONE;
      end
      if (ren) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end
endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: fill/drain, boundary collisions, random traffic, mid-run reset.
module tb_async_fifo;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pushes = 0;
  int   pops = 0;
  logic [DSIZE-1:0] exp_q[$];
  logic [DSIZE-1:0] wval;
  logic wa;
  logic ra;

  async_fifo_if #(.DSIZE(DSIZE)) bus ();

  async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;

    // reset then idle
    rst = 1'b1;
    repeat (5) cycle();
    chk("rst_empty", 32'(bus.rempty), 32'd1);
    chk("rst_full", 32'(bus.wfull), 32'd0);
    rst = 1'b0;
    repeat (3) cycle();
    chk("idle_empty", 32'(bus.rempty), 32'd1);
    chk("idle_full", 32'(bus.wfull), 32'd0);

    // fill to full
    for (int i = 0; i < DEPTH; i++) begin
      bus.winc  = 1'b1;
      bus.wdata = 8'hA5 + 8'(i);
      cycle();
      chk("fill_empty", 32'(bus.rempty), 32'd0);
      chk("fill_full", 32'(bus.wfull), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    chk("fill_head", 32'(bus.rdata), 32'hA5);
    bus.wdata = 8'hB5;
    cycle();
    bus.winc = 1'b0;
    chk("overflow_full", 32'(bus.wfull), 32'd1);
    chk("overflow_head", 32'(bus.rdata), 32'hA5);

    // drain
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", 32'(bus.rdata), 32'hA5 + 32'(i));
      bus.rinc = 1'b1;
      cycle();
      chk("drain_notfull", 32'(bus.wfull), 32'd0);
    end
    bus.rinc = 1'b0;
    chk("drain_empty", 32'(bus.rempty), 32'd1);

    // empty guard
    bus.rinc = 1'b1;
    repeat (3) begin
      cycle();
      chk("guard_empty", 32'(bus.rempty), 32'd1);
    end
    bus.rinc  = 1'b0;
    bus.winc  = 1'b1;
    bus.wdata = 8'h3C;
    cycle();
    bus.winc = 1'b0;
    chk("guard_data", 32'(bus.rdata), 32'h3C);
    chk("guard_notempty", 32'(bus.rempty), 32'd0);
    bus.rinc = 1'b1;
    cycle();
    bus.rinc = 1'b0;
    chk("guard_single", 32'(bus.rempty), 32'd1);

    // simultaneous while empty: write wins
    bus.winc  = 1'b1;
    bus.rinc  = 1'b1;
    bus.wdata = 8'h5A;
    cycle();
    bus.rinc = 1'b0;
    chk("sim_empty_notempty", 32'(bus.rempty), 32'd0);
    chk("sim_empty_data", 32'(bus.rdata), 32'h5A);
    for (int i = 1; i < DEPTH; i++) begin
      bus.wdata = 8'h60 + 8'(i);
      cycle();
    end
    chk("sim_refill_full", 32'(bus.wfull), 32'd1);

    // simultaneous while full: pop wins, write refused
    bus.rinc  = 1'b1;
    bus.wdata = 8'hEE;
    cycle();
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    chk("sim_full_notfull", 32'(bus.wfull), 32'd0);
    chk("sim_full_head", 32'(bus.rdata), 32'h61);
    for (int i = 1; i < DEPTH; i++) begin
      chk("sim_drain", 32'(bus.rdata), 32'h60 + 32'(i));
      bus.rinc = 1'b1;
      cycle();
    end
    bus.rinc = 1'b0;
    chk("sim_drain_empty", 32'(bus.rempty), 32'd1);

    // random traffic against a reference queue
    exp_q.delete();
    wval = 8'hA5;
    for (int c = 0; c < 600; c++) begin
      bus.winc  = ($urandom_range(0, 99) < 75);
      bus.rinc  = ($urandom_range(0, 99) < 70);
      bus.wdata = wval;
      chk("rnd_empty", 32'(bus.rempty), (exp_q.size() == 0) ? 32'd1 : 32'd0);
      chk("rnd_full", 32'(bus.wfull), (exp_q.size() == DEPTH) ? 32'd1 : 32'd0);
      if (exp_q.size() > 0) chk("rnd_data", 32'(bus.rdata), 32'(exp_q[0]));
      wa = bus.winc && (exp_q.size() < DEPTH);
      ra = bus.rinc && (exp_q.size() > 0);
      cycle();
      if (ra) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (wa) begin
        exp_q.push_back(wval);
        wval = wval + 8'd1;
        pushes++;
      end
    end
    bus.winc = 1'b0;
    while (exp_q.size() > 0) begin
      chk("rnd_drain_data", 32'(bus.rdata), 32'(exp_q[0]));
      bus.rinc = 1'b1;
      cycle();
      void'(exp_q.pop_front());
      pops++;
    end
    bus.rinc = 1'b0;
    chk("rnd_final_empty", 32'(bus.rempty), 32'd1);
    chk("rnd_push_pop", 32'(pops), 32'(pushes));
    chk("rnd_wraps", 32'(pushes >= 4 * DEPTH), 32'd1);

    // mid-operation reset
    bus.winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wdata = 8'h20 + 8'(i);
      cycle();
    end
    chk("pre_rst_notempty", 32'(bus.rempty), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(bus.rempty), 32'd1);
    chk("mid_rst_full", 32'(bus.wfull), 32'd0);
    bus.wdata = 8'h99;
    repeat (2) cycle();
    chk("rst_held_empty", 32'(bus.rempty), 32'd1);
    bus.winc = 1'b0;
    rst = 1'b0;
    cycle();
    chk("post_rst_empty", 32'(bus.rempty), 32'd1);
    bus.winc  = 1'b1;
    bus.wdata = 8'h11;
    cycle();
    bus.wdata = 8'h12;
    cycle();
    bus.winc = 1'b0;
    chk("post_rst_first", 32'(bus.rdata), 32'h11);
    bus.rinc = 1'b1;
    cycle();
    chk("post_rst_second", 32'(bus.rdata), 32'h12);
    cycle();
    bus.rinc = 1'b0;
    chk("post_rst_drained", 32'(bus.rempty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
